// File: rtl/siren_pattern_gen.sv
// Emergency-light pattern generator for a WS2812B chain: SWAP, CHASE, STROBE and OFF
// patterns stepped by rising edges of a slow tick, emitted as a packed GRB word.
module siren_pattern_gen #(
  parameter int unsigned NUM_LEDS       = 4,
  parameter logic [23:0] COLOR_A        = 24'h00FF00,
  parameter logic [23:0] COLOR_B        = 24'h0000FF,
  parameter int unsigned TICKS_PER_STEP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     enable,
  input  logic [1:0]               mode,
  output logic [24*NUM_LEDS-1:0]   ledData,
  output logic                     frameValid
);

  // Phase must also hold STROBE's 0..7 range when the chain is short.
  localparam int unsigned PW = ($clog2(2*NUM_LEDS) > 3) ? $clog2(2*NUM_LEDS) : 3;
  localparam int unsigned CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int unsigned H  = NUM_LEDS / 2;

  typedef enum logic [1:0] {
    SWAP   = 2'd0,
    CHASE  = 2'd1,
    STROBE = 2'd2,
    OFF    = 2'd3
  } modeT;

  logic          tickPrev;
  logic [CW-1:0] tickCnt;
  logic [PW-1:0] phase;
  logic [PW-1:0] nextPhase;
  modeT          modeReg;
  modeT          modeIn;
  logic          tickEdge;

  assign modeIn   = modeT'(mode);
  assign tickEdge = tick & ~tickPrev;

  function automatic logic [24*NUM_LEDS-1:0] pattern(input modeT m, input logic [PW-1:0] p);
    logic [24*NUM_LEDS-1:0] r;
    int unsigned pu;
    int unsigned lit;
    r   = '0;
    pu  = 32'(p);
    lit = (pu < NUM_LEDS) ? pu : pu - NUM_LEDS;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      case (m)
        SWAP:    r[24*i +: 24] = ((i < H) == (pu == 0)) ? COLOR_A : COLOR_B;
        CHASE:   if (i == lit) r[24*i +: 24] = (pu < NUM_LEDS) ? COLOR_A : COLOR_B;
        STROBE:  if (!p[0]) r[24*i +: 24] = (pu < 4) ? COLOR_A : COLOR_B;
        default: r[24*i +: 24] = '0;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    nextPhase = '0;
    case (modeReg)
      SWAP:    nextPhase = (phase == '0) ? PW'(1) : '0;
      CHASE:   nextPhase = (phase == PW'(2*NUM_LEDS-1)) ? '0 : phase + PW'(1);
      STROBE:  nextPhase = (phase == PW'(7)) ? '0 : phase + PW'(1);
      default: nextPhase = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tickPrev   <= 1'b1;
      tickCnt    <= '0;
      phase      <= '0;
      modeReg    <= OFF;
      ledData    <= '0;
      frameValid <= 1'b0;
    end else begin
      tickPrev   <= tick;
      frameValid <= 1'b0;
      // A mode change wins over enable and swallows any coincident edge.
      if (modeIn != modeReg) begin
        modeReg    <= modeIn;
        phase      <= '0;
        tickCnt    <= '0;
        ledData    <= pattern(modeIn, '0);
        frameValid <= 1'b1;
      end else if (tickEdge && enable) begin
        if (tickCnt == CW'(TICKS_PER_STEP-1)) begin
          tickCnt    <= '0;
          phase      <= nextPhase;
          ledData    <= pattern(modeReg, nextPhase);
          frameValid <= 1'b1;
        end else begin
          tickCnt <= tickCnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_siren_pattern_gen.sv
// Scoreboard bench: two instances (1 and 2 ticks per step) with independent tick/mode,
// every frameValid pops and checks an expected frame.
module tb_siren_pattern_gen;

  localparam logic [23:0] CA = 24'h00FF00;
  localparam logic [23:0] CB = 24'h0000FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        tick1, tick2;
  logic [1:0]  mode1, mode2;
  logic [95:0] led1, led2;
  logic        fv1, fv2;

  int total = 0;
  int bad   = 0;
  logic [95:0] q1[$];
  logic [95:0] q2[$];
  logic [95:0] e1, e2, hold;

  always #5 clk = ~clk;

  siren_pattern_gen #(.NUM_LEDS(4), .COLOR_A(CA), .COLOR_B(CB), .TICKS_PER_STEP(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick1), .enable(enable), .mode(mode1),
    .ledData(led1), .frameValid(fv1)
  );

  siren_pattern_gen #(.NUM_LEDS(4), .COLOR_A(CA), .COLOR_B(CB), .TICKS_PER_STEP(2)) dut2 (
    .clk(clk), .reset(reset), .tick(tick2), .enable(enable), .mode(mode2),
    .ledData(led2), .frameValid(fv2)
  );

  // Reference patterns for a 4-LED chain, built LED by LED.
  function automatic logic [95:0] model(input int m, input int p);
    logic [23:0] led [4];
    for (int i = 0; i < 4; i++) led[i] = 24'h0;
    case (m)
      0: for (int i = 0; i < 4; i++) led[i] = ((i >= 2) == (p == 1)) ? CA : CB;
      1: led[p % 4] = (p >= 4) ? CB : CA;
      2: if (p % 2 == 0) for (int i = 0; i < 4; i++) led[i] = (p >= 4) ? CB : CA;
      default: ;
    endcase
    return {led[3], led[2], led[1], led[0]};
  endfunction

  always @(negedge clk) begin
    if (fv1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL dut1_unexpected_frame got=%h want=no frame", led1);
      end else begin
        e1 = q1.pop_front();
        if (led1 !== e1) begin
          bad++;
          $display("FAIL dut1_frame got=%h want=%h", led1, e1);
        end
      end
    end
    if (fv2) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL dut2_unexpected_frame got=%h want=no frame", led2);
      end else begin
        e2 = q2.pop_front();
        if (led2 !== e2) begin
          bad++;
          $display("FAIL dut2_frame got=%h want=%h", led2, e2);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    if (which == 1) tick1 = 1'b0; else tick2 = 1'b0;
    cycles(2);
    if (which == 1) tick1 = 1'b1; else tick2 = 1'b1;
    cycles(3);
  endtask

  task automatic drained(input string name);
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_frames got=%0d/%0d pending want=0/0", name, q1.size(), q2.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; tick1 = 1'b1; tick2 = 1'b0; mode1 = 2'd0; mode2 = 2'd3;
    cycles(3);
    total++;
    if (led1 !== 96'h0 || fv1 !== 1'b0 || led2 !== 96'h0) begin
      bad++;
      $display("FAIL reset_state got=%h/%b want=0/0", led1, fv1);
    end
    q1.push_back(96'h0000FF_0000FF_00FF00_00FF00);
    reset = 1'b0;
    cycles(1);
    total++;
    if (fv1 !== 1'b1 || led1 !== 96'h0000FF_0000FF_00FF00_00FF00) begin
      bad++;
      $display("FAIL reset_release_load got=%h/%b want=0000ff0000ff00ff0000ff00/1", led1, fv1);
    end
    cycles(1);
    total++;
    if (fv1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_single_pulse got=%b want=0", fv1);
    end
    hold = led1;
    tick1 = 1'b0;
    cycles(3);
    total++;
    if (led1 !== hold) begin
      bad++;
      $display("FAIL swap_fall_no_change got=%h want=%h", led1, hold);
    end
    q1.push_back(96'h00FF00_00FF00_0000FF_0000FF);
    tick1 = 1'b1;
    cycles(1);
    total++;
    if (fv1 !== 1'b1 || led1 !== 96'h00FF00_00FF00_0000FF_0000FF) begin
      bad++;
      $display("FAIL swap_step_latency got=%h/%b want=00ff0000ff000000ff0000ff/1", led1, fv1);
    end
    cycles(6);
    drained("swap");
  endtask

  task automatic test_chase;
    q1.push_back(model(1, 0));
    mode1 = 2'd1;
    cycles(3);
    for (int k = 1; k <= 8; k++) begin
      q1.push_back(model(1, k % 8));
      pulse(1);
    end
    drained("chase");
  endtask

  task automatic test_strobe;
    q2.push_back(model(2, 0));
    mode2 = 2'd2;
    cycles(3);
    for (int k = 1; k <= 16; k++) begin
      if (k % 2 == 0) q2.push_back(model(2, (k / 2) % 8));
      pulse(2);
    end
    drained("strobe");
  endtask

  task automatic test_back_to_back;
    q1.push_back(model(0, 0));
    mode1 = 2'd0;
    cycles(3);
    tick1 = 1'b0;
    cycles(2);
    q1.push_back(model(2, 0));
    tick1 = 1'b1;
    mode1 = 2'd2;
    cycles(3);
    drained("mode_edge_load");
    q1.push_back(model(2, 1));
    pulse(1);
    drained("mode_edge_next");
  endtask

  task automatic test_enable;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) pulse(1);
    drained("enable_off");
    enable = 1'b1;
    cycles(2);
    q1.push_back(model(2, 2));
    pulse(1);
    drained("enable_on");
  endtask

  task automatic test_reset_mid;
    q1.push_back(model(1, 0));
    mode1 = 2'd1;
    cycles(3);
    for (int k = 1; k <= 2; k++) begin
      q1.push_back(model(1, k));
      pulse(1);
    end
    tick1 = 1'b0;
    cycles(2);
    tick1 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (fv1 !== 1'b1 || led1 !== model(1, 3)) begin
      bad++;
      $display("FAIL mid_frame_before_reset got=%h/%b want=%h/1", led1, fv1, model(1, 3));
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (led1 !== 96'h0 || fv1 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_clear got=%h/%b want=0/0", led1, fv1);
    end
    cycles(2);
    q1.push_back(model(1, 0));
    q2.push_back(model(2, 0));
    reset = 1'b0;
    cycles(3);
    drained("reset_reload");
    q1.push_back(model(1, 1));
    pulse(1);
    drained("reset_resume");
  endtask

  initial begin
    test_reset;
    test_chase;
    test_strobe;
    test_back_to_back;
    test_enable;
    test_reset_mid;
    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
